// File: rtl/bram_sdp_pipe.sv
// Simple-dual-port single-clock RAM with byte-enabled writes, 1- or 2-cycle reads,
// write-first collision forwarding and a zero-fill sweep after reset or on request.
module bram_sdp_pipe #(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 128,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter     INIT_FILE      = "",
  localparam int ADDR_W        = $clog2(RAM_DEPTH),
  localparam int BE_W          = RAM_WIDTH / 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  output logic                 o_busy,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [BE_W-1:0]      i_wr_be,
  input  logic [RAM_WIDTH-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [RAM_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam state_t            RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    cnt, cnt_nxt;
  logic                 busy;
  logic                 wr_ok, rd_ok;

  logic [RAM_WIDTH-1:0] ram_q_p1;
  logic [RAM_WIDTH-1:0] wdata_p1;
  logic [BE_W-1:0]      be_p1;
  logic                 hit_p1;
  logic                 zero_p1;
  logic                 vld_p1;
  logic [RAM_WIDTH-1:0] rd_merged;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_EXT;
  endfunction

  function automatic logic [RAM_WIDTH-1:0] byte_merge(input logic [RAM_WIDTH-1:0] old_word,
                                                      input logic [RAM_WIDTH-1:0] new_word,
                                                      input logic [BE_W-1:0]      be);
    logic [RAM_WIDTH-1:0] m;
    m = old_word;
    for (int k = 0; k < BE_W; k++)
      if (be[k]) m[8*k +: 8] = new_word[8*k +: 8];
    return m;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (i_clr) state_nxt = CLEAR;
      CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign o_busy = busy;
  assign wr_ok  = i_wr_en && !busy && in_range(i_wr_addr);
  assign rd_ok  = i_rd_en && !busy;

  always_ff @(posedge i_clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < BE_W; k++)
        if (i_wr_be[k]) mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
    end
  end

  // p1: raw RAM word plus the same-cycle write needed for write-first forwarding
  always_ff @(posedge i_clk) begin
    if (rd_ok) begin
      ram_q_p1 <= mem[i_rd_addr];
      hit_p1   <= wr_ok && (i_wr_addr == i_rd_addr);
      wdata_p1 <= i_wr_data;
      be_p1    <= i_wr_be;
    end
  end

  // zero_p1 resets high so the output reads zero until the first completed read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b1;
    end else begin
      vld_p1 <= rd_ok;
      if (rd_ok) zero_p1 <= !in_range(i_rd_addr);
    end
  end

  assign rd_merged = zero_p1 ? '0 : byte_merge(ram_q_p1, wdata_p1, hit_p1 ? be_p1 : '0);

  // p2: optional output register stage
  if (READ_LATENCY == 2) begin : g_lat2
    logic [RAM_WIDTH-1:0] rd_data_p2;
    logic                 vld_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rd_data_p2 <= '0;
        vld_p2     <= 1'b0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) rd_data_p2 <= rd_merged;
      end
    end

    assign o_rd_data  = rd_data_p2;
    assign o_rd_valid = vld_p2;
  end else begin : g_lat1
    assign o_rd_data  = rd_merged;
    assign o_rd_valid = vld_p1;
  end

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// Bench for bram_sdp_pipe: instance A (depth 128, latency 1) and instance B
// (depth 100, latency 2), both compared every cycle against an array-based model.
module tb_bram_sdp_pipe;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clr      [N];
  logic        busy     [N];
  logic        wr_en    [N];
  logic [6:0]  wr_addr  [N];
  logic [3:0]  wr_be    [N];
  logic [31:0] wr_data  [N];
  logic        rd_en    [N];
  logic [6:0]  rd_addr  [N];
  logic [31:0] rd_data  [N];
  logic        rd_valid [N];

  bram_sdp_pipe #(.RAM_WIDTH(32), .RAM_DEPTH(128), .READ_LATENCY(1),
                  .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr[0]), .o_busy(busy[0]),
    .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]), .i_wr_be(wr_be[0]), .i_wr_data(wr_data[0]),
    .i_rd_en(rd_en[0]), .i_rd_addr(rd_addr[0]), .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]));

  bram_sdp_pipe #(.RAM_WIDTH(32), .RAM_DEPTH(100), .READ_LATENCY(2),
                  .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr[1]), .o_busy(busy[1]),
    .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]), .i_wr_be(wr_be[1]), .i_wr_data(wr_data[1]),
    .i_rd_en(rd_en[1]), .i_rd_addr(rd_addr[1]), .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]));

  // Reference model state
  logic [31:0] mm   [N][128];
  int          sweep_left [N];
  logic        ev   [N][4];
  logic [31:0] ed   [N][4];
  logic [31:0] last [N];
  int          cyc;
  int          vectors;
  int          miscompares;

  function automatic int depth_of(input int i);
    return (i == 0) ? 128 : 100;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset(input int i);
    sweep_left[i] = depth_of(i);
    last[i] = 32'h0;
    for (int s = 0; s < 4; s++) ev[i][s] = 1'b0;
  endtask

  task automatic model_edge(input int i);
    int d;
    int s;
    d = depth_of(i);
    if (!rst_n) begin
      model_reset(i);
    end else if (sweep_left[i] > 0) begin
      mm[i][d - sweep_left[i]] = 32'h0;
      sweep_left[i]--;
    end else begin
      if (wr_en[i] && int'(wr_addr[i]) < d)
        for (int b = 0; b < 4; b++)
          if (wr_be[i][b]) mm[i][wr_addr[i]][8*b +: 8] = wr_data[i][8*b +: 8];
      if (rd_en[i]) begin
        s = (cyc + lat_of(i) - 1) % 4;
        ev[i][s] = 1'b1;
        ed[i][s] = (int'(rd_addr[i]) < d) ? mm[i][rd_addr[i]] : 32'h0;
      end
      if (clr[i]) sweep_left[i] = d;
    end
  endtask

  task automatic check_one(input int i);
    int s;
    s = cyc % 4;
    chk($sformatf("valid[%0d]@%0d", i, cyc), 32'(rd_valid[i]), 32'(ev[i][s]));
    if (ev[i][s]) last[i] = ed[i][s];
    ev[i][s] = 1'b0;
    chk($sformatf("data[%0d]@%0d", i, cyc), rd_data[i], last[i]);
    chk($sformatf("busy[%0d]@%0d", i, cyc), 32'(busy[i]), 32'(sweep_left[i] > 0));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) model_edge(i);
    #1;
    for (int i = 0; i < N; i++) check_one(i);
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      clr[i] = 1'b0; wr_en[i] = 1'b0; rd_en[i] = 1'b0;
    end
  endtask

  task automatic set_wr(input int i, input int a, input logic [3:0] be, input logic [31:0] d);
    wr_en[i] = 1'b1; wr_addr[i] = 7'(a); wr_be[i] = be; wr_data[i] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_en[i] = 1'b1; rd_addr[i] = 7'(a);
  endtask

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    for (int i = 0; i < N; i++) begin
      wr_addr[i] = '0; wr_be[i] = '0; wr_data[i] = '0; rd_addr[i] = '0;
      for (int a = 0; a < 128; a++) mm[i][a] = 32'h0;
      model_reset(i);
    end
    idle_all();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (132) tick();

    // Post-reset reads of swept memory
    for (int k = 0; k < 3; k++) begin
      set_rd(0, (k == 0) ? 0 : (k == 1) ? 64 : 127);
      set_rd(1, (k == 0) ? 0 : (k == 1) ? 50 : 99);
      tick();
    end
    idle_all(); repeat (3) tick();

    // Byte-enabled overwrite
    for (int i = 0; i < N; i++) set_wr(i, 5, 4'hF, 32'hDEADBEEF);
    tick();
    for (int i = 0; i < N; i++) set_wr(i, 5, 4'b0101, 32'h11223344);
    tick(); idle_all();
    for (int i = 0; i < N; i++) set_rd(i, 5);
    tick(); idle_all(); repeat (3) tick();
    for (int i = 0; i < N; i++) chk($sformatf("be_merge[%0d]", i), rd_data[i], 32'hDE22BE44);

    // Same-cycle write/read collision
    for (int i = 0; i < N; i++) set_wr(i, 9, 4'hF, 32'h01020304);
    tick();
    for (int i = 0; i < N; i++) begin set_wr(i, 9, 4'b1100, 32'hAABBCCDD); set_rd(i, 9); end
    tick(); idle_all(); repeat (3) tick();
    for (int i = 0; i < N; i++) chk($sformatf("collide[%0d]", i), rd_data[i], 32'hAABB0304);

    // Back-to-back reads
    for (int a = 0; a < 8; a++) begin
      for (int i = 0; i < N; i++) set_wr(i, a, 4'hF, 32'(a * 3));
      tick();
    end
    idle_all();
    for (int a = 0; a < 8; a++) begin
      for (int i = 0; i < N; i++) set_rd(i, a);
      tick();
    end
    idle_all(); repeat (3) tick();
    for (int i = 0; i < N; i++) chk($sformatf("b2b_last[%0d]", i), rd_data[i], 32'd21);

    // Address 100: in range for A, out of range for B
    for (int i = 0; i < N; i++) set_wr(i, 100, 4'hF, 32'hFFFFFFFF);
    tick(); idle_all();
    for (int i = 0; i < N; i++) set_rd(i, 100);
    tick(); idle_all(); repeat (3) tick();
    chk("a_rd100", rd_data[0], 32'hFFFFFFFF);
    chk("b_oob_rd", rd_data[1], 32'h0);

    // Clear with same-cycle access, then traffic and a second clear during the sweep
    for (int i = 0; i < N; i++) begin
      set_wr(i, 3, 4'hF, 32'h12345678); set_rd(i, 3); clr[i] = 1'b1;
    end
    tick(); idle_all();
    for (int k = 0; k < 135; k++) begin
      for (int i = 0; i < N; i++) begin
        if (sweep_left[i] > 0) begin
          set_wr(i, $urandom_range(0, 127), 4'(($urandom)), $urandom);
          set_rd(i, $urandom_range(0, 127));
          clr[i] = (k == 20);
        end else begin
          wr_en[i] = 1'b0; rd_en[i] = 1'b0; clr[i] = 1'b0;
        end
      end
      tick();
    end
    idle_all();
    for (int a = 0; a < 128; a++) begin
      for (int i = 0; i < N; i++) set_rd(i, a);
      tick();
    end
    idle_all(); repeat (3) tick();

    // Random traffic with occasional clears
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++) begin
        wr_en[i]   = 1'($urandom);
        wr_addr[i] = 7'($urandom);
        wr_be[i]   = 4'($urandom);
        wr_data[i] = $urandom;
        rd_en[i]   = 1'($urandom);
        rd_addr[i] = 7'($urandom);
        clr[i]     = ($urandom_range(0, 199) == 0);
      end
      tick();
    end
    idle_all(); repeat (130) tick();

    // Reset 40 cycles into a sweep, with a read in flight at sweep start
    for (int i = 0; i < N; i++) begin set_rd(i, 1); clr[i] = 1'b1; end
    tick(); idle_all();
    repeat (40) tick();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) model_reset(i);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 32'(rd_valid[i]), 32'h0);
      chk($sformatf("rst_data[%0d]", i), rd_data[i], 32'h0);
      chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'h1);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (132) tick();
    for (int a = 0; a < 4; a++) begin
      for (int i = 0; i < N; i++) set_rd(i, a * 30);
      tick();
    end
    idle_all(); repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
